// File: rtl/accumulate_pkg.sv
// Shared definitions for the accumulator stream interface.
// Used by accumulate_driver (initiator side) and by the accumulator itself.
//   FP_W    : width of one IEEE-754 single-precision word
//   FP_ZERO : all-zero word driven on data whenever valid is low
//   state_e : one-hot state encoding of the driver FSM
package accumulate_pkg;

  localparam int              FP_W    = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'd0;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_START  = 6'b000010,
    ST_STREAM = 6'b000100,
    ST_FLUSH  = 6'b001000,
    ST_FINISH = 6'b010000,
    ST_WAIT   = 6'b100000
  } state_e;

endpackage

// File: rtl/stream_addr_gen.sv
// Read-address generator for a sync-read vector memory.
// A load captures the element count and rewinds the address to 0. While en
// is high and elements remain, one read is issued per cycle. valid is the
// issue strobe delayed by the one-cycle memory read latency, so it lines up
// with the returned read data; last marks the final valid of the stream.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : rewind address, capture load_len
//   load_len  : number of reads to issue (1 .. 2**ADDR_W)
//   en        : permission to issue reads this cycle
//   addr      : memory read address
//   valid     : read data for an issued address is present this cycle
//   last      : this valid is the final one of the stream
module stream_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W:0]   load_len,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              issue;

  assign issue = en && (rem_q != '0);

  // After the final read the address has stepped once more; for a full
  // 2**ADDR_W stream that step wraps it back to 0.
  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    valid_d = issue;
    last_d  = issue && (rem_q == (ADDR_W+1)'(1));
    if (load) begin
      addr_d = '0;
      rem_d  = load_len;
    end else if (issue) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign addr  = addr_q;
  assign valid = valid_q;
  assign last  = last_q;

endmodule

// File: rtl/accumulate_driver.sv
// Initiator side of the accumulator stream interface.
// On req with a non-zero len it pulses start, streams len words read from the
// vector memory as back-to-back valid/data beats, idles FLUSH_CYCLES cycles to
// drain the adder pipeline, pulses finished, then waits for acc_done and
// latches acc_result into result with a one-cycle result_valid pulse.
// req with len==0 completes immediately with result=0.
// Handshake: start, valid and finished are mutually exclusive one-cycle
// qualifiers; data is FP_ZERO whenever valid is low; acc_result is only
// sampled in a WAIT cycle where acc_done is high.
// Optional feature macro ACC_DRV_TIMEOUT_EN: a watchdog in WAIT gives up after
// TIMEOUT_CYCLES cycles without acc_done, pulsing error with result=0.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req, len              : launch request and element count (IDLE only)
//   mem_addr, mem_rdata   : sync-read vector memory port
//   start, valid, data,
//   finished              : stream to accumulator
//   acc_done, acc_result  : completion and sum from accumulator
//   busy                  : high in every state except IDLE
//   result, result_valid  : latched sum and its update pulse
//   error                 : watchdog pulse (constant 0 without the macro)
//   dbg_state             : current FSM state
module accumulate_driver
  import accumulate_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int FLUSH_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [FP_W-1:0]   mem_rdata,
  output logic              start,
  output logic              valid,
  output logic [FP_W-1:0]   data,
  output logic              finished,
  input  logic              acc_done,
  input  logic [FP_W-1:0]   acc_result,
  output logic              busy,
  output logic [FP_W-1:0]   result,
  output logic              result_valid,
  output logic              error,
  output state_e            dbg_state
);

  // One counter serves both the flush drain and the WAIT watchdog.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FP_W-1:0]   result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              load;
  logic              stream_en;
  logic              beat_valid;
  logic              beat_last;

  stream_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_len (len),
    .en       (stream_en),
    .addr     (mem_addr),
    .valid    (beat_valid),
    .last     (beat_last)
  );

  // Address 0 goes out during START so the first beat lands right after it.
  assign stream_en = (state_q == ST_START) || (state_q == ST_STREAM);

`ifdef ACC_DRV_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic error_q, error_d;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    load           = 1'b0;
`ifdef ACC_DRV_TIMEOUT_EN
    error_d        = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (len != '0) begin
            load    = 1'b1;
            state_d = ST_START;
          end else begin
            result_d       = FP_ZERO;
            result_valid_d = 1'b1;
          end
        end
      end
      ST_START: state_d = ST_STREAM;
      ST_STREAM: begin
        cnt_d = '0;
        if (beat_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FINISH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (acc_done) begin
          result_d       = acc_result;
          result_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end
`ifdef ACC_DRV_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          result_d       = FP_ZERO;
          result_valid_d = 1'b1;
          error_d        = 1'b1;
          cnt_d          = '0;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      result_q       <= FP_ZERO;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

`ifdef ACC_DRV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) error_q <= 1'b0;
    else     error_q <= error_d;
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign start        = (state_q == ST_START);
  assign finished     = (state_q == ST_FINISH);
  assign valid        = beat_valid;
  assign data         = beat_valid ? mem_rdata : FP_ZERO;
  assign busy         = (state_q != ST_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_accumulate_driver.sv
module tb_accumulate_driver;
  import accumulate_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        req = 1'b0;
  logic [6:0]  len = '0;
  logic [5:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        start, valid, finished, busy, result_valid, error;
  logic [31:0] data, result;
  logic        acc_done;
  logic [31:0] acc_value = '0;
  state_e      dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  accumulate_driver dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .len          (len),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .start        (start),
    .valid        (valid),
    .data         (data),
    .finished     (finished),
    .acc_done     (acc_done),
    .acc_result   (acc_value),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .error        (error),
    .dbg_state    (dbg_state)
  );

  // ---------------- sync-read ROM ----------------
  logic [31:0] rom [64];
  always @(posedge clk) mem_rdata <= rom[mem_addr];

  // ---------------- accumulator model: done 7 cycles after finished ----------------
  logic model_done = 1'b0;
  logic model_arm  = 1'b0;
  logic model_mute = 1'b0;
  logic done_force = 1'b0;
  int   model_cnt  = 0;
  always @(posedge clk) begin
    if (start) begin
      model_done <= 1'b0;
      model_arm  <= 1'b0;
    end else if (finished) begin
      model_arm <= !model_mute;
      model_cnt <= 1;
    end else if (model_arm) begin
      if (model_cnt == 6) begin
        model_done <= 1'b1;
        model_arm  <= 1'b0;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end
  end
  assign acc_done = model_done | done_force;

  // ---------------- event monitor ----------------
  int start_cnt = 0, valid_cnt = 0, fin_cnt = 0, proto_bad = 0;
  always @(posedge clk) begin
    if (start === 1'b1)    start_cnt <= start_cnt + 1;
    if (valid === 1'b1)    valid_cnt <= valid_cnt + 1;
    if (finished === 1'b1) fin_cnt   <= fin_cnt + 1;
    if ((32'(start) + 32'(valid) + 32'(finished)) > 1 || (valid === 1'b0 && data !== 32'd0))
      proto_bad <= proto_bad + 1;
  end

  // Waits up to budget negedges for result_valid; cycles=-1 if never seen.
  task automatic wait_result(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        cycles = c;
        return;
      end
    end
  endtask

  task automatic launch(input logic [6:0] n);
    @(negedge clk);
    req = 1'b1;
    len = n;
    @(negedge clk);
    req = 1'b0;
    len = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({start, valid, finished, busy, result_valid, error} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got s/v/f/b/rv/e=%b expected 000000", {start, valid, finished, busy, result_valid, error});
    end
    tests_run++;
    if (result !== 32'd0 || data !== 32'd0 || mem_addr !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_data: result=%h data=%h addr=%0d expected 0 0 0", result, data, mem_addr);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected %b", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int s0, v0, f0, cyc;
    logic ok;
    for (int i = 0; i < 64; i++) rom[i] = (i < 4) ? 32'h3F800000 : 32'h0;
    acc_value = 32'h40800000;
    s0 = start_cnt; v0 = valid_cnt; f0 = fin_cnt;
    launch(7'd4);
    tests_run++;
    if (start !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_start: s/v/b=%b%b%b expected 101", start, valid, busy);
    end
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (valid !== 1'b1 || data !== 32'h3F800000 || start !== 1'b0) ok = 1'b0;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL basic_stream: got bad beat, expected 4 beats of 3f800000");
    end
    // acc_done pulsed during FLUSH must be ignored.
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      done_force = (k == 2);
      if (valid !== 1'b0 || data !== 32'd0 || finished !== 1'b0) ok = 1'b0;
    end
    done_force = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL basic_flush: got activity in flush, expected 8 idle cycles");
    end
    @(negedge clk);
    tests_run++;
    if (finished !== 1'b1 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_finished: finished=%b valid=%b expected 1 0", finished, valid);
    end
    wait_result(20, cyc);
    tests_run++;
    if (cyc != 8) begin
      tests_failed++;
      $display("FAIL basic_latency: result_valid at %0d cycles after finished, expected 8", cyc);
    end
    tests_run++;
    if (result !== 32'h40800000 || busy !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: result=%h busy=%b error=%b expected 40800000 0 0", result, busy, error);
    end
    @(negedge clk);
    tests_run++;
    if (result_valid !== 1'b0 || result !== 32'h40800000) begin
      tests_failed++;
      $display("FAIL basic_hold: rv=%b result=%h expected 0 40800000", result_valid, result);
    end
    tests_run++;
    if (start_cnt - s0 != 1 || valid_cnt - v0 != 4 || fin_cnt - f0 != 1) begin
      tests_failed++;
      $display("FAIL basic_counts: start=%0d valid=%0d fin=%0d expected 1 4 1", start_cnt - s0, valid_cnt - v0, fin_cnt - f0);
    end
  endtask

  task automatic test_len0();
    int s0, v0, f0;
    s0 = start_cnt; v0 = valid_cnt; f0 = fin_cnt;
    launch(7'd0);
    tests_run++;
    if (result_valid !== 1'b1 || result !== 32'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL len0_result: rv=%b result=%h busy=%b expected 1 0 0", result_valid, result, busy);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (result_valid !== 1'b0 || start_cnt != s0 || valid_cnt != v0 || fin_cnt != f0) begin
      tests_failed++;
      $display("FAIL len0_quiet: rv=%b starts=%0d valids=%0d fins=%0d expected 0 0 0 0", result_valid, start_cnt - s0, valid_cnt - v0, fin_cnt - f0);
    end
  endtask

  task automatic test_len64();
    int bad, v0, cyc;
    for (int i = 0; i < 64; i++) rom[i] = 32'(i);
    acc_value = 32'h12345678;
    v0 = valid_cnt;
    launch(7'd64);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (valid !== 1'b1 || data !== 32'(i)) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL len64_order: got %0d bad beats, expected 0", bad);
    end
    tests_run++;
    if (mem_addr !== 6'd0) begin
      tests_failed++;
      $display("FAIL len64_wrap: addr=%0d expected 0", mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b0 || mem_addr !== 6'd0) begin
      tests_failed++;
      $display("FAIL len64_extra: valid=%b addr=%0d expected 0 0", valid, mem_addr);
    end
    wait_result(40, cyc);
    tests_run++;
    if (cyc < 0 || result !== 32'h12345678 || busy !== 1'b0 || valid_cnt - v0 != 64) begin
      tests_failed++;
      $display("FAIL len64_result: cyc=%0d result=%h busy=%b valids=%0d expected rv,12345678,0,64", cyc, result, busy, valid_cnt - v0);
    end
  endtask

  task automatic test_reset_mid();
    int f0, cyc;
    logic ok;
    for (int i = 0; i < 64; i++) rom[i] = 32'(i);
    acc_value = 32'h3F000000;
    f0 = fin_cnt;
    launch(7'd4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({start, valid, finished, busy, result_valid} !== 5'b0 || data !== 32'd0 || mem_addr !== 6'd0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL rstmid_clear: s/v/f/b/rv=%b data=%h addr=%0d state=%b expected all 0, IDLE",
               {start, valid, finished, busy, result_valid}, data, mem_addr, dbg_state);
    end
    launch(7'd2);
    tests_run++;
    if (start !== 1'b1 || fin_cnt != f0) begin
      tests_failed++;
      $display("FAIL rstmid_restart: start=%b fins=%0d expected 1 0", start, fin_cnt - f0);
    end
    ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (valid !== 1'b1 || data !== 32'(k)) ok = 1'b0;
    end
    @(negedge clk);
    if (valid !== 1'b0) ok = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rstmid_stream: got wrong beats, expected data 0,1 then idle");
    end
    wait_result(30, cyc);
    tests_run++;
    if (cyc < 0 || result !== 32'h3F000000) begin
      tests_failed++;
      $display("FAIL rstmid_result: cyc=%0d result=%h expected 3f000000", cyc, result);
    end
  endtask

  task automatic test_req_in_wait();
    int s0, rv_n, bad;
    logic seen;
    rom[0] = 32'h40400000;
    acc_value = 32'h40400000;
    s0 = start_cnt;
    launch(7'd1);
    repeat (10) @(negedge clk);  // one beat, eight flush cycles, finished
    tests_run++;
    if (finished !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_finished: finished=%b expected 1", finished);
    end
    @(negedge clk);
    req = 1'b1;
    len = 7'd3;
    @(negedge clk);
    req = 1'b0;
    len = '0;
    rv_n = 0; bad = 0; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        rv_n++;
        seen = 1'b1;
      end else if (!seen && busy !== 1'b1) begin
        bad++;
      end
    end
    tests_run++;
    if (rv_n != 1 || bad != 0 || start_cnt - s0 != 1 || result !== 32'h40400000) begin
      tests_failed++;
      $display("FAIL wait_req_ignored: rv=%0d busy_drops=%0d starts=%0d result=%h expected 1 0 1 40400000",
               rv_n, bad, start_cnt - s0, result);
    end
  endtask

`ifdef ACC_DRV_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    rom[0] = 32'h3F800000;
    model_mute = 1'b1;
    launch(7'd1);
    repeat (10) @(negedge clk);
    wait_result(300, cyc);
    tests_run++;
    if (cyc != 256 || error !== 1'b1 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL timeout: cyc=%0d error=%b result=%h expected 256 1 0", cyc, error, result);
    end
    @(negedge clk);
    tests_run++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: error=%b busy=%b expected 0 0", error, busy);
    end
    model_mute = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    test_reset();
    test_basic();
    test_len0();
    test_len64();
    test_reset_mid();
    test_req_in_wait();
`ifdef ACC_DRV_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    tests_run++;
    if (proto_bad != 0) begin
      tests_failed++;
      $display("FAIL protocol: got %0d overlapping/non-zero-idle cycles, expected 0", proto_bad);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
